// File: rtl/urv_dm_issue_pkg.sv
// Shared definitions for the data-memory issue unit: funct3 load/store codes,
// AHB-Lite encodings, FSM state type and the funct3 -> HSIZE mapping.
package urv_dm_issue_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    localparam logic [1:0] AHB_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] AHB_HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] AHB_HSIZE_B = 3'b000;
    localparam logic [2:0] AHB_HSIZE_H = 3'b001;
    localparam logic [2:0] AHB_HSIZE_W = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } dm_state_t;

    // Access width depends only on funct3[1:0]; bit 2 only selects sign/zero extension.
    function automatic logic [2:0] fun_to_hsize(input logic [2:0] fun);
        case (fun[1:0])
            2'b00:   return AHB_HSIZE_B;
            2'b01:   return AHB_HSIZE_H;
            default: return AHB_HSIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/urv_dm_issue_if.sv
// Execute-side request signals plus the AHB-Lite data port and writeback
// attributes. master = the issue unit, slave = pipeline/bus side.
interface urv_dm_issue_if;
    logic        x_valid_i;
    logic        x_kill_i;
    logic        x_stall_i;
    logic        x_load_i;
    logic        x_store_i;
    logic [2:0]  x_fun_i;
    logic [31:0] x_dm_addr_i;
    logic [31:0] x_rs2_value_i;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] x_HWDATA_o;
    logic        x_stall_req_o;
    logic        x_misalign_o;
    logic        w_load_o;
    logic        w_store_o;
    logic [2:0]  w_fun_o;
    logic [31:0] w_dm_addr_o;
    logic        w_bus_err_o;

    modport master (
        input  x_valid_i, x_kill_i, x_stall_i, x_load_i, x_store_i, x_fun_i,
               x_dm_addr_i, x_rs2_value_i, HREADY, HRESP,
        output HADDR, HTRANS, HSIZE, HWRITE, x_HWDATA_o, x_stall_req_o,
               x_misalign_o, w_load_o, w_store_o, w_fun_o, w_dm_addr_o, w_bus_err_o
    );

    modport slave (
        output x_valid_i, x_kill_i, x_stall_i, x_load_i, x_store_i, x_fun_i,
               x_dm_addr_i, x_rs2_value_i, HREADY, HRESP,
        input  HADDR, HTRANS, HSIZE, HWRITE, x_HWDATA_o, x_stall_req_o,
               x_misalign_o, w_load_o, w_store_o, w_fun_o, w_dm_addr_o, w_bus_err_o
    );
endinterface

// File: rtl/urv_dm_align.sv
// Combinational access decode: transfer size, alignment check and store data
// replicated across all byte lanes so the slave can pick any lane.
module urv_dm_align
    import urv_dm_issue_pkg::*;
(
    input  logic [2:0]  fun,
    input  logic [1:0]  addr_lsb,
    input  logic        is_store,
    input  logic [31:0] rs2,
    output logic        misaligned,
    output logic [2:0]  hsize,
    output logic [31:0] wdata
);

    assign hsize = fun_to_hsize(fun);

    assign misaligned = ((hsize == AHB_HSIZE_H) && addr_lsb[0]) ||
                        ((hsize == AHB_HSIZE_W) && (addr_lsb != 2'b00));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_byte;

            // Pick the source byte of rs2 that lands on lane gi for this size.
            always_comb begin
                case (hsize)
                    AHB_HSIZE_B: lane_byte = rs2[7:0];
                    AHB_HSIZE_H: lane_byte = rs2[8*(gi%2) +: 8];
                    default:     lane_byte = rs2[8*gi +: 8];
                endcase
            end

            assign wdata[8*gi +: 8] = is_store ? lane_byte : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/urv_dm_issue.sv
// Load/store address-phase unit on the AHB-Lite data port. One transfer is in
// flight at a time; a new address phase may start on the edge the previous
// data phase completes without error.
module urv_dm_issue
    import urv_dm_issue_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    urv_dm_issue_if.master  bus
);

    dm_state_t   state_reg;
    logic [1:0]  htrans_reg;
    logic [31:0] haddr_reg;
    logic [2:0]  hsize_reg;
    logic        hwrite_reg;
    logic [31:0] hwdata_reg;
    logic        w_load_reg;
    logic        w_store_reg;
    logic [2:0]  w_fun_reg;
    logic [31:0] w_dm_addr_reg;
    logic        w_bus_err_reg;

    logic        req;
    logic        misaligned;
    logic        aligned_req;
    logic        can_accept;
    logic        accept;
    logic [2:0]  hsize_next;
    logic [31:0] hwdata_next;

    urv_dm_align u_align (
        .fun        (bus.x_fun_i),
        .addr_lsb   (bus.x_dm_addr_i[1:0]),
        .is_store   (bus.x_store_i),
        .rs2        (bus.x_rs2_value_i),
        .misaligned (misaligned),
        .hsize      (hsize_next),
        .wdata      (hwdata_next)
    );

    assign req = bus.x_valid_i & (bus.x_load_i | bus.x_store_i) &
                 ~bus.x_kill_i & ~bus.x_stall_i;
    assign aligned_req = req & ~misaligned;

    // An error response never frees the port on its final cycle: the next
    // request waits one cycle so writeback sees the error first.
    assign can_accept = (state_reg == ST_IDLE) |
                        ((state_reg == ST_DATA) & bus.HREADY & ~bus.HRESP);
    assign accept = aligned_req & can_accept;

    assign bus.x_stall_req_o = aligned_req & ~can_accept;
    assign bus.x_misalign_o  = req & misaligned;

    // Issue FSM: accept into the address phase, advance through the data phase on HREADY.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            htrans_reg    <= AHB_HTRANS_IDLE;
            haddr_reg     <= '0;
            hsize_reg     <= AHB_HSIZE_B;
            hwrite_reg    <= 1'b0;
            hwdata_reg    <= '0;
            w_load_reg    <= 1'b0;
            w_store_reg   <= 1'b0;
            w_fun_reg     <= '0;
            w_dm_addr_reg <= '0;
            w_bus_err_reg <= 1'b0;
        end else begin
            w_bus_err_reg <= 1'b0;
            if (accept) begin
                state_reg     <= ST_ADDR;
                htrans_reg    <= AHB_HTRANS_NONSEQ;
                haddr_reg     <= bus.x_dm_addr_i;
                hsize_reg     <= hsize_next;
                hwrite_reg    <= bus.x_store_i;
                hwdata_reg    <= hwdata_next;
                w_load_reg    <= bus.x_load_i;
                w_store_reg   <= bus.x_store_i;
                w_fun_reg     <= bus.x_fun_i;
                w_dm_addr_reg <= bus.x_dm_addr_i;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ST_IDLE;
                    end
                    ST_ADDR: begin
                        if (bus.HREADY) begin
                            state_reg  <= ST_DATA;
                            htrans_reg <= AHB_HTRANS_IDLE;
                        end
                    end
                    ST_DATA: begin
                        if (bus.HREADY) begin
                            state_reg     <= ST_IDLE;
                            w_bus_err_reg <= bus.HRESP;
                        end
                    end
                    default: begin
                        state_reg  <= ST_IDLE;
                        htrans_reg <= AHB_HTRANS_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.HADDR       = haddr_reg;
    assign bus.HTRANS      = htrans_reg;
    assign bus.HSIZE       = hsize_reg;
    assign bus.HWRITE      = hwrite_reg;
    assign bus.x_HWDATA_o  = hwdata_reg;
    assign bus.w_load_o    = w_load_reg;
    assign bus.w_store_o   = w_store_reg;
    assign bus.w_fun_o     = w_fun_reg;
    assign bus.w_dm_addr_o = w_dm_addr_reg;
    assign bus.w_bus_err_o = w_bus_err_reg;

endmodule

// File: tb/tb_urv_dm_issue.sv
// Bench for urv_dm_issue: directed vector table, a hand-written reset/misalign
// sequence, then random traffic against a pipeline-slot reference model.
module tb_urv_dm_issue;

    bit clk = 1'b0;
    bit rst = 1'b1;
    int n_cmp  = 0;
    int n_fail = 0;

    urv_dm_issue_if dm_if ();

    urv_dm_issue dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (dm_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst, vld, ld, st, kill, xs;
        bit [2:0]  fun;
        bit [31:0] addr, rs2;
        bit        rdy, resp;
        bit        e_stall, e_mis;
        bit [1:0]  e_trans;
        bit        chk;
        bit [31:0] e_haddr;
        bit [2:0]  e_hsize;
        bit        e_hwrite;
        bit [31:0] e_hwdata;
        bit [4:0]  e_wctl;
        bit        e_werr;
        bit [31:0] e_waddr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit vld, input bit ld, input bit st,
                         input bit kill, input bit xs, input bit [2:0] fun,
                         input bit [31:0] addr, input bit [31:0] rs2,
                         input bit rdy, input bit resp);
        rst                 = r;
        dm_if.x_valid_i     = vld;
        dm_if.x_load_i      = ld;
        dm_if.x_store_i     = st;
        dm_if.x_kill_i      = kill;
        dm_if.x_stall_i     = xs;
        dm_if.x_fun_i       = fun;
        dm_if.x_dm_addr_i   = addr;
        dm_if.x_rs2_value_i = rs2;
        dm_if.HREADY        = rdy;
        dm_if.HRESP         = resp;
    endtask

    task automatic add(input bit r, input bit vld, input bit ld, input bit st,
                       input bit kill, input bit xs, input bit [2:0] fun,
                       input bit [31:0] addr, input bit [31:0] rs2,
                       input bit rdy, input bit resp,
                       input bit e_stall, input bit e_mis, input bit [1:0] e_trans,
                       input bit c, input bit [31:0] e_haddr, input bit [2:0] e_hsize,
                       input bit e_hwrite, input bit [31:0] e_hwdata, input bit [4:0] e_wctl,
                       input bit e_werr, input bit [31:0] e_waddr);
        vec_t v;
        v.rst = r; v.vld = vld; v.ld = ld; v.st = st; v.kill = kill; v.xs = xs;
        v.fun = fun; v.addr = addr; v.rs2 = rs2; v.rdy = rdy; v.resp = resp;
        v.e_stall = e_stall; v.e_mis = e_mis; v.e_trans = e_trans; v.chk = c;
        v.e_haddr = e_haddr; v.e_hsize = e_hsize; v.e_hwrite = e_hwrite;
        v.e_hwdata = e_hwdata; v.e_wctl = e_wctl; v.e_werr = e_werr; v.e_waddr = e_waddr;
        vecs.push_back(v);
    endtask

    // No request, HREADY high: the FSM just advances, nothing new on the bus.
    task automatic add_idle(input bit [31:0] waddr);
        add(0,0,0,0,0,0,0,0,0,1,0, 0,0,2'b00,0,0,0,0,0,0,0,waddr);
    endtask

    task automatic check_wctl(input string name, input bit [4:0] exp);
        chk(name, 32'({dm_if.w_load_o, dm_if.w_store_o, dm_if.w_fun_o}), 32'(exp));
    endtask

    // ---------------- reference model: one address slot, one data slot ----------------
    bit        m_aph, m_dph, m_err;
    bit        m_ld, m_st;
    bit [2:0]  m_fun, m_size;
    bit [31:0] m_addr, m_wdata;

    function automatic bit [2:0] size_of(input bit [2:0] fun);
        if (fun == 3'd0 || fun == 3'd4) return 3'd0;
        if (fun == 3'd1 || fun == 3'd5) return 3'd1;
        return 3'd2;
    endfunction

    function automatic bit misal_of(input bit [2:0] fun, input bit [31:0] addr);
        int bytes;
        bytes = 1 << size_of(fun);
        return (addr % bytes) != 0;
    endfunction

    function automatic bit [31:0] lanes_of(input bit [2:0] fun, input bit [31:0] rs2);
        case (size_of(fun))
            3'd0:    return {24'd0, rs2[7:0]} * 32'h01010101;
            3'd1:    return {16'd0, rs2[15:0]} * 32'h00010001;
            default: return rs2;
        endcase
    endfunction

    task automatic model_reset();
        m_aph = 0; m_dph = 0; m_err = 0; m_ld = 0; m_st = 0;
        m_fun = 0; m_size = 0; m_addr = 0; m_wdata = 0;
    endtask

    initial begin
        bit [2:0] funs [5];
        funs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        drive(1,0,0,0,0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.htrans", 32'(dm_if.HTRANS), 32'd0);
        chk("rst.haddr",  dm_if.HADDR, 32'd0);
        chk("rst.hsize",  32'(dm_if.HSIZE), 32'd0);
        chk("rst.hwrite", 32'(dm_if.HWRITE), 32'd0);
        check_wctl("rst.wctl", 5'd0);
        chk("rst.waddr",  dm_if.w_dm_addr_o, 32'd0);
        chk("rst.werr",   32'(dm_if.w_bus_err_o), 32'd0);
        chk("rst.stall",  32'(dm_if.x_stall_req_o), 32'd0);
        chk("rst.mis",    32'(dm_if.x_misalign_o), 32'd0);

        // ---------------- directed vector table ----------------
        // SW word, single transfer
        add(0,1,0,1,0,0,2,'h1000,'hDEADBEEF,1,0, 0,0,2'b10,1,'h1000,2,1,'hDEADBEEF,5'b01010,0,'h1000);
        add_idle('h1000);
        add_idle('h1000);
        // SB replicates the byte
        add(0,1,0,1,0,0,0,'h2003,'h000000A5,1,0, 0,0,2'b10,1,'h2003,0,1,'hA5A5A5A5,5'b01000,0,'h2003);
        // LH waits during ADDR, then issues as the SB data phase ends
        add(0,1,1,0,0,0,1,'h2002,0,1,0, 1,0,2'b00,0,0,0,0,0,0,0,'h2003);
        add(0,1,1,0,0,0,1,'h2002,0,1,0, 0,0,2'b10,1,'h2002,1,0,0,5'b10001,0,'h2002);
        // back-to-back LW
        add(0,1,1,0,0,0,2,'h3000,0,1,0, 1,0,2'b00,0,0,0,0,0,0,0,'h2002);
        add(0,1,1,0,0,0,2,'h3000,0,1,0, 0,0,2'b10,1,'h3000,2,0,0,5'b10010,0,'h3000);
        add_idle('h3000);
        add_idle('h3000);
        // LW with 3 ADDR wait states and 2 DATA wait states, pending SW stalled throughout
        add(0,1,1,0,0,0,2,'h4000,0,1,0, 0,0,2'b10,1,'h4000,2,0,0,5'b10010,0,'h4000);
        add(0,1,0,1,0,0,2,'h4100,'h12345678,0,0, 1,0,2'b10,1,'h4000,2,0,0,5'b10010,0,'h4000);
        add(0,1,0,1,0,0,2,'h4100,'h12345678,0,0, 1,0,2'b10,1,'h4000,2,0,0,5'b10010,0,'h4000);
        add(0,1,0,1,0,0,2,'h4100,'h12345678,0,0, 1,0,2'b10,1,'h4000,2,0,0,5'b10010,0,'h4000);
        add(0,1,0,1,0,0,2,'h4100,'h12345678,1,0, 1,0,2'b00,1,'h4000,2,0,0,5'b10010,0,'h4000);
        add(0,1,0,1,0,0,2,'h4100,'h12345678,0,0, 1,0,2'b00,1,'h4000,2,0,0,5'b10010,0,'h4000);
        add(0,1,0,1,0,0,2,'h4100,'h12345678,0,0, 1,0,2'b00,1,'h4000,2,0,0,5'b10010,0,'h4000);
        add(0,1,0,1,0,0,2,'h4100,'h12345678,1,0, 0,0,2'b10,1,'h4100,2,1,'h12345678,5'b01010,0,'h4100);
        add_idle('h4100);
        add_idle('h4100);
        // misaligned LW and LHU: pulse, no transfer, no stall; aligned LHU then issues
        add(0,1,1,0,0,0,2,'h5002,0,1,0, 0,1,2'b00,0,0,0,0,0,0,0,'h4100);
        add(0,1,1,0,0,0,5,'h5001,0,1,0, 0,1,2'b00,0,0,0,0,0,0,0,'h4100);
        add(0,1,1,0,0,0,5,'h5002,0,1,0, 0,0,2'b10,1,'h5002,1,0,0,5'b10101,0,'h5002);
        add_idle('h5002);
        add_idle('h5002);
        // killed / globally stalled requests are ignored, even misaligned ones
        add(0,1,0,1,1,0,2,'h6000,'h1,1,0, 0,0,2'b00,0,0,0,0,0,0,0,'h5002);
        add(0,1,0,1,0,1,2,'h6000,'h1,1,0, 0,0,2'b00,0,0,0,0,0,0,0,'h5002);
        add(0,1,1,0,1,0,2,'h6001,0,1,0, 0,0,2'b00,0,0,0,0,0,0,0,'h5002);
        // SH accepted, later kill/stall do not disturb it
        add(0,1,0,1,0,0,1,'h6002,'h0000BEEF,1,0, 0,0,2'b10,1,'h6002,1,1,'hBEEFBEEF,5'b01001,0,'h6002);
        add(0,1,1,0,1,1,2,'h7000,0,1,0, 0,0,2'b00,0,0,0,0,0,0,0,'h6002);
        add_idle('h6002);
        // two-cycle error response, SW stalled on the error edge and issued next cycle
        add(0,1,1,0,0,0,2,'h7000,0,1,0, 0,0,2'b10,1,'h7000,2,0,0,5'b10010,0,'h7000);
        add_idle('h7000);
        add(0,1,0,1,0,0,2,'h7100,'hCAFEF00D,0,1, 1,0,2'b00,0,0,0,0,0,0,0,'h7000);
        add(0,1,0,1,0,0,2,'h7100,'hCAFEF00D,1,1, 1,0,2'b00,0,0,0,0,0,0,1,'h7000);
        add(0,1,0,1,0,0,2,'h7100,'hCAFEF00D,1,0, 0,0,2'b10,1,'h7100,2,1,'hCAFEF00D,5'b01010,0,'h7100);
        add_idle('h7100);
        add_idle('h7100);
        // reset held two cycles in the middle of an address phase
        add(0,1,1,0,0,0,2,'h8000,0,1,0, 0,0,2'b10,1,'h8000,2,0,0,5'b10010,0,'h8000);
        add(1,0,0,0,0,0,0,0,0,0,0, 0,0,2'b00,1,0,0,0,0,5'b00000,0,0);
        add(1,0,0,0,0,0,0,0,0,0,0, 0,0,2'b00,1,0,0,0,0,5'b00000,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.rst, v.vld, v.ld, v.st, v.kill, v.xs, v.fun, v.addr, v.rs2, v.rdy, v.resp);
            @(negedge clk);
            chk($sformatf("v%0d.stall", i), 32'(dm_if.x_stall_req_o), 32'(v.e_stall));
            chk($sformatf("v%0d.mis", i),   32'(dm_if.x_misalign_o),  32'(v.e_mis));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.htrans", i), 32'(dm_if.HTRANS), 32'(v.e_trans));
            chk($sformatf("v%0d.werr", i),   32'(dm_if.w_bus_err_o), 32'(v.e_werr));
            chk($sformatf("v%0d.waddr", i),  dm_if.w_dm_addr_o, v.e_waddr);
            if (v.chk) begin
                chk($sformatf("v%0d.haddr", i),  dm_if.HADDR, v.e_haddr);
                chk($sformatf("v%0d.hsize", i),  32'(dm_if.HSIZE), 32'(v.e_hsize));
                chk($sformatf("v%0d.hwrite", i), 32'(dm_if.HWRITE), 32'(v.e_hwrite));
                chk($sformatf("v%0d.hwdata", i), dm_if.x_HWDATA_o, v.e_hwdata);
                check_wctl($sformatf("v%0d.wctl", i), v.e_wctl);
            end
        end

        // ---------------- hand-written: reset abandons a stuck data phase ----------------
        drive(0,1,1,0,0,0,2,'h9000,0,1,0);
        @(posedge clk); #1;
        chk("h.issue", 32'(dm_if.HTRANS), 32'd2);
        drive(0,0,0,0,0,0,0,0,0,1,0);
        @(posedge clk); #1;
        chk("h.data", 32'(dm_if.HTRANS), 32'd0);
        drive(1,0,0,0,0,0,0,0,0,0,0);
        @(posedge clk); #1;
        chk("h.rst.waddr", dm_if.w_dm_addr_o, 32'd0);
        // stray HRESP/HREADY after reset belong to no transfer
        drive(0,1,0,1,0,0,2,'h9104,'h55667788,1,1);
        @(negedge clk);
        chk("h.stall", 32'(dm_if.x_stall_req_o), 32'd0);
        @(posedge clk); #1;
        chk("h.sw.htrans", 32'(dm_if.HTRANS), 32'd2);
        chk("h.sw.haddr", dm_if.HADDR, 32'h9104);
        chk("h.sw.werr", 32'(dm_if.w_bus_err_o), 32'd0);
        // misaligned request while busy: pulse only, not stalled, not latched
        drive(0,1,1,0,0,0,2,'h9002,0,1,0);
        @(negedge clk);
        chk("h.busy.mis", 32'(dm_if.x_misalign_o), 32'd1);
        chk("h.busy.stall", 32'(dm_if.x_stall_req_o), 32'd0);
        @(posedge clk); #1;
        chk("h.busy.waddr", dm_if.w_dm_addr_o, 32'h9104);
        chk("h.busy.htrans", 32'(dm_if.HTRANS), 32'd0);
        drive(0,0,0,0,0,0,0,0,0,1,0);
        @(posedge clk); #1;

        // ---------------- random traffic against the model ----------------
        drive(1,0,0,0,0,0,0,0,0,1,0);
        @(posedge clk); #1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit r, vld, ld, st, kill, xs, rdy, resp;
            bit [2:0]  fun;
            bit [31:0] addr, rs2;
            int op;
            bit busy, req, mis, acc, n_aph, n_dph;
            r    = ($urandom_range(0, 199) == 0);
            op   = $urandom_range(0, 3);
            ld   = (op == 1);
            st   = (op >= 2);
            vld  = ($urandom_range(0, 3) != 0);
            kill = ($urandom_range(0, 7) == 0);
            xs   = ($urandom_range(0, 7) == 0);
            fun  = funs[$urandom_range(0, 4)];
            addr = $urandom;
            rs2  = $urandom;
            rdy  = ($urandom_range(0, 3) != 0);
            resp = ($urandom_range(0, 7) == 0);
            drive(r, vld, ld, st, kill, xs, fun, addr, rs2, rdy, resp);

            busy = m_aph || (m_dph && !(rdy && !resp));
            req  = vld && (ld || st) && !kill && !xs;
            mis  = misal_of(fun, addr);
            acc  = req && !mis && !busy;
            @(negedge clk);
            chk($sformatf("r%0d.stall", c), 32'(dm_if.x_stall_req_o), 32'(req && !mis && busy));
            chk($sformatf("r%0d.mis", c),   32'(dm_if.x_misalign_o),  32'(req && mis));
            @(posedge clk);
            if (r) begin
                model_reset();
            end else begin
                m_err = m_dph && rdy && resp;
                n_dph = m_aph ? rdy : (m_dph && !rdy);
                n_aph = acc || (m_aph && !rdy);
                if (acc) begin
                    m_ld = ld; m_st = st; m_fun = fun; m_addr = addr;
                    m_size = size_of(fun);
                    m_wdata = st ? lanes_of(fun, rs2) : 32'd0;
                end
                m_aph = n_aph;
                m_dph = n_dph;
            end
            #1;
            chk($sformatf("r%0d.htrans", c), 32'(dm_if.HTRANS), m_aph ? 32'd2 : 32'd0);
            chk($sformatf("r%0d.haddr", c),  dm_if.HADDR, m_addr);
            chk($sformatf("r%0d.hsize", c),  32'(dm_if.HSIZE), 32'(m_size));
            chk($sformatf("r%0d.hwrite", c), 32'(dm_if.HWRITE), 32'(m_st));
            chk($sformatf("r%0d.hwdata", c), dm_if.x_HWDATA_o, m_wdata);
            check_wctl($sformatf("r%0d.wctl", c), {m_ld, m_st, m_fun});
            chk($sformatf("r%0d.waddr", c),  dm_if.w_dm_addr_o, m_addr);
            chk($sformatf("r%0d.werr", c),   32'(dm_if.w_bus_err_o), 32'(m_err));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
